// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port, word-wide data memory between two requesters:
//   port 0 : CPU load/store unit
//   port 1 : debug / program loader
// One request is in flight at a time. Each one walks a small FSM:
//   IDLE -> ACCESS -> RESP                  (load, full store, zero-be store)
//   IDLE -> ACCESS -> MERGE_WR -> RESP      (partial store, read-modify-write)
// The memory only writes whole 32-bit words, so a partial store reads the old
// word in ACCESS and writes the byte-merged word in MERGE_WR.
//
// Configuration macro:
//   DMEM_ARB_FIXED_PRIO_EN  defined   : port 0 always wins contention
//                           undefined : round-robin between ports (default)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   m0_req/m1_req            request valid
//   m*_wen                   1 = store, 0 = load
//   m*_addr  [ADDR_W-1:0]    word address
//   m*_be    [3:0]           byte enables for m*_wdata
//   m*_wdata [31:0]          store data
//   m*_ready                 request accepted this cycle (combinational, IDLE)
//   m*_done                  one-cycle completion pulse
//   m*_rdata [31:0]          load data, valid with m*_done (0 for stores)
//   mem_wen                  memory write enable
//   mem_addr [ADDR_W-1:0]    memory word address
//   mem_wdata[31:0]          memory write data
//   mem_rdata[31:0]          memory read data (combinational from mem_addr)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  // port 0
  input  logic              m0_req,
  input  logic              m0_wen,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_be,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ready,
  output logic              m0_done,
  output logic [31:0]       m0_rdata,
  // port 1
  input  logic              m1_req,
  input  logic              m1_wen,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_be,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ready,
  output logic              m1_done,
  output logic [31:0]       m1_rdata,
  // data memory
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_MERGE_WR = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

  // Byte-wise merge: enabled bytes come from the new data, the rest keep the
  // old memory contents.
  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  // FSM state and the latched transaction
  state_e              state_q, state_d;
  logic                gnt_id_q, gnt_id_d;
  logic                wen_l_q, wen_l_d;
  logic [ADDR_W-1:0]   addr_l_q, addr_l_d;
  logic [3:0]          be_l_q, be_l_d;
  logic [31:0]         wdata_l_q, wdata_l_d;

  // Registered memory-side and response-side outputs
  logic                mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                m0_done_q, m0_done_d;
  logic                m1_done_q, m1_done_d;
  logic [31:0]         m0_rdata_q, m0_rdata_d;
  logic [31:0]         m1_rdata_q, m1_rdata_d;

  // Arbitration
  logic                gnt_valid_s;
  logic                gnt_id_s;
  logic                sel_wen_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [3:0]          sel_be_s;
  logic [31:0]         sel_wdata_s;

  // Response dispatch helpers
  logic                resp_en_s;
  logic [31:0]         resp_data_s;

`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic                rr_q, rr_d;
`endif

  assign gnt_valid_s = m0_req | m1_req;

  // Pick the winning port for this IDLE cycle
  always_comb begin
    gnt_id_s = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    if (m0_req) begin
      gnt_id_s = 1'b0;
    end else begin
      gnt_id_s = 1'b1;
    end
`else
    if (m0_req && m1_req) begin
      gnt_id_s = rr_q;
    end else if (m0_req) begin
      gnt_id_s = 1'b0;
    end else begin
      gnt_id_s = 1'b1;
    end
`endif
  end

  assign sel_wen_s   = gnt_id_s ? m1_wen   : m0_wen;
  assign sel_addr_s  = gnt_id_s ? m1_addr  : m0_addr;
  assign sel_be_s    = gnt_id_s ? m1_be    : m0_be;
  assign sel_wdata_s = gnt_id_s ? m1_wdata : m0_wdata;

  // Ready is the only combinational handshake output; it is suppressed while
  // reset is asserted because the accepting edge would be a reset edge.
  assign m0_ready = (state_q == ST_IDLE) & gnt_valid_s & ~gnt_id_s & ~rst;
  assign m1_ready = (state_q == ST_IDLE) & gnt_valid_s &  gnt_id_s & ~rst;

  // Reset in the write cycle must abort the write, so the registered enable is
  // masked by rst in the same cycle. Done is masked the same way so an abort
  // never leaks a completion.
  assign mem_wen   = mem_wen_q & ~rst;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign m0_done   = m0_done_q & ~rst;
  assign m1_done   = m1_done_q & ~rst;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    gnt_id_d    = gnt_id_q;
    wen_l_d     = wen_l_q;
    addr_l_d    = addr_l_q;
    be_l_d      = be_l_q;
    wdata_l_d   = wdata_l_q;
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    resp_en_s   = 1'b0;
    resp_data_s = 32'h0000_0000;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    rr_d        = rr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          gnt_id_d   = gnt_id_s;
          wen_l_d    = sel_wen_s;
          addr_l_d   = sel_addr_s;
          be_l_d     = sel_be_s;
          wdata_l_d  = sel_wdata_s;
          // Address and full-word write data are presented from the first
          // ACCESS cycle, so they are loaded on the accepting edge.
          mem_addr_d = sel_addr_s;
          if (sel_wen_s && (sel_be_s == 4'hF)) begin
            mem_wen_d   = 1'b1;
            mem_wdata_d = sel_wdata_s;
          end else begin
            mem_wen_d   = 1'b0;
          end
`ifndef DMEM_ARB_FIXED_PRIO_EN
          rr_d       = ~gnt_id_s;
`endif
          state_d    = ST_ACCESS;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        if (!wen_l_q) begin
          resp_en_s   = 1'b1;
          resp_data_s = mem_rdata;
          state_d     = ST_RESP;
        end else if ((be_l_q == 4'hF) || (be_l_q == 4'h0)) begin
          // Full store was written this cycle; empty store writes nothing.
          resp_en_s   = 1'b1;
          resp_data_s = 32'h0000_0000;
          state_d     = ST_RESP;
        end else begin
          // The old word is captured already merged, so MERGE_WR only has to
          // raise the write enable.
          mem_wen_d   = 1'b1;
          mem_wdata_d = merge_bytes(mem_rdata, wdata_l_q, be_l_q);
          state_d     = ST_MERGE_WR;
        end
      end

      ST_MERGE_WR: begin
        resp_en_s   = 1'b1;
        resp_data_s = 32'h0000_0000;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Route the response to the granted port only; the other port stays at 0
  always_comb begin
    m0_done_d  = 1'b0;
    m1_done_d  = 1'b0;
    m0_rdata_d = 32'h0000_0000;
    m1_rdata_d = 32'h0000_0000;
    if (resp_en_s) begin
      if (gnt_id_q) begin
        m1_done_d  = 1'b1;
        m1_rdata_d = resp_data_s;
      end else begin
        m0_done_d  = 1'b1;
        m0_rdata_d = resp_data_s;
      end
    end else begin
      m0_done_d  = 1'b0;
      m1_done_d  = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_id_q    <= 1'b0;
      wen_l_q     <= 1'b0;
      addr_l_q    <= {ADDR_W{1'b0}};
      be_l_q      <= 4'h0;
      wdata_l_q   <= 32'h0000_0000;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= 32'h0000_0000;
      m0_done_q   <= 1'b0;
      m1_done_q   <= 1'b0;
      m0_rdata_q  <= 32'h0000_0000;
      m1_rdata_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      gnt_id_q    <= gnt_id_d;
      wen_l_q     <= wen_l_d;
      addr_l_q    <= addr_l_d;
      be_l_q      <= be_l_d;
      wdata_l_q   <= wdata_l_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      m0_done_q   <= m0_done_d;
      m1_done_q   <= m1_done_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

`ifndef DMEM_ARB_FIXED_PRIO_EN
  // Round-robin pointer: port 0 is favoured out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: reset state, a table of single
// transactions, hand-written arbitration and reset-abort sequences, and a
// randomized phase checked against a transaction-level reference model.
module tb_dmem_arbiter;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0, m0_wen = 1'b0, m1_req = 1'b0, m1_wen = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [3:0]    m0_be = 4'h0, m1_be = 4'h0;
  logic [31:0]   m0_wdata = 32'h0, m1_wdata = 32'h0;
  logic          m0_ready, m0_done, m1_ready, m1_done;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_be(m0_be),
    .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_be(m1_be),
    .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_done(m1_done), .m1_rdata(m1_rdata),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory: combinational read, whole-word write on posedge.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic          clr = 1'b0, pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0]   pre_data = 32'h0;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= 32'h0;
    end else if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_wen) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic set_port(input logic p, input logic req, input logic wen,
                          input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] wd);
    if (p) begin m1_req = req; m1_wen = wen; m1_addr = a; m1_be = be; m1_wdata = wd; end
    else   begin m0_req = req; m0_wen = wen; m0_addr = a; m0_be = be; m0_wdata = wd; end
  endtask

  task automatic rst_pulse();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  // One transaction on port p; reports latency, data, and observed writes.
  task automatic do_req(input logic p, input logic wen, input logic [AW-1:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output int nwen,
                        output int wen_off, output logic [31:0] wwd, output logic other_done);
    int  t_rdy;
    bit  fin;
    t_rdy = -1; fin = 1'b0;
    lat = -1; rd = 32'h0; nwen = 0; wen_off = -1; wwd = 32'h0; other_done = 1'b0;
    @(posedge clk); #1;
    set_port(p, 1'b1, wen, a, be, wd);
    for (int i = 0; i < 20 && !fin; i++) begin
      @(negedge clk);
      if (t_rdy < 0 && (p ? m1_ready : m0_ready)) t_rdy = cyc;
      if (t_rdy >= 0 && cyc > t_rdy) begin
        if (mem_wen) begin nwen++; wen_off = cyc - t_rdy; wwd = mem_wdata; end
        if (p ? m0_done : m1_done) other_done = 1'b1;
        if (p ? m1_done : m0_done) begin
          lat = cyc - t_rdy; rd = p ? m1_rdata : m0_rdata; fin = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (t_rdy >= 0) set_port(p, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    end
  endtask

  typedef struct {
    logic          port;
    logic          wen;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic          pre;
    logic [31:0]   init;
    logic [31:0]   exp_rdata;
    int            exp_lat;
    int            exp_wen_off;   // -1: no write expected
    logic [31:0]   exp_wdata;
    logic [31:0]   exp_word;
  } vec_t;
  vec_t vt [8];

  // ---------------- randomized phase: reference model ----------------
  bit           rnd_on = 1'b0;
  logic         rdy0_seen = 1'b0, rdy1_seen = 1'b0;
  logic [31:0]  ref_mem [0:15];
  bit           m_infl = 1'b0;
  logic         m_port = 1'b0, m_rr = 1'b0;
  int           m_done_cyc = 0, m_wen_cyc = -1;
  logic [31:0]  m_rdata = 32'h0, m_wdata = 32'h0;
  logic [AW-1:0] m_addr = '0;

  always @(negedge clk) begin
    if (rnd_on) begin
      logic e_d0, e_d1, e_w, g_any, g_id;
      rdy0_seen = m0_ready;
      rdy1_seen = m1_ready;
      if (m_infl && cyc > m_done_cyc) m_infl = 1'b0;
      e_d0 = m_infl && cyc == m_done_cyc && !m_port;
      e_d1 = m_infl && cyc == m_done_cyc &&  m_port;
      e_w  = m_infl && cyc == m_wen_cyc;
      chk("rnd_done", {m0_done, m1_done}, {e_d0, e_d1});
      chk("rnd_wen", mem_wen, e_w);
      if (e_w) begin
        chk("rnd_wdata", mem_wdata, m_wdata);
        chk("rnd_waddr", mem_addr, m_addr);
      end
      if (e_d0 || e_d1) begin
        chk("rnd_rdata0", m0_rdata, e_d0 ? m_rdata : 32'h0);
        chk("rnd_rdata1", m1_rdata, e_d1 ? m_rdata : 32'h0);
      end
      // Arbitration rule: only when nothing is in flight
      g_any = !m_infl && (m0_req || m1_req);
      if (m0_req && m1_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        g_id = 1'b0;
`else
        g_id = m_rr;
`endif
      end else begin
        g_id = m1_req;
      end
      chk("rnd_ready", {m0_ready, m1_ready}, {g_any && !g_id, g_any && g_id});
      if (g_any) begin
        logic w; logic [3:0] be; logic [31:0] wd; logic [AW-1:0] a;
        w  = g_id ? m1_wen : m0_wen;   be = g_id ? m1_be : m0_be;
        wd = g_id ? m1_wdata : m0_wdata; a = g_id ? m1_addr : m0_addr;
        m_infl = 1'b1; m_port = g_id; m_rr = ~g_id; m_addr = a;
        m_rdata = w ? 32'h0 : ref_mem[a[3:0]];
        m_wen_cyc = -1; m_done_cyc = cyc + 2;
        if (w && be == 4'hF) begin
          m_wen_cyc = cyc + 1; m_wdata = wd;
        end else if (w && be != 4'h0) begin
          m_wen_cyc = cyc + 2; m_done_cyc = cyc + 3;
          for (int b = 0; b < 4; b++)
            m_wdata[8*b +: 8] = be[b] ? wd[8*b +: 8] : ref_mem[a[3:0]][8*b +: 8];
        end
        if (m_wen_cyc >= 0) ref_mem[a[3:0]] = m_wdata;
      end
    end
  end

  initial begin
    int lat, nwen, woff, g [4], t [4], ng, t0;
    logic [31:0] rd, wwd;
    logic od, seen;

    // ---------------- reset state ----------------
    rst = 1'b1; clr = 1'b1;
    set_port(1'b0, 1'b1, 1'b0, 10'h000, 4'hF, 32'h0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("rst_ready", {m0_ready, m1_ready}, 2'b00);
    chk("rst_done", {m0_done, m1_done}, 2'b00);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
    chk("rst_mem_wen", mem_wen, 1'b0);
    chk("rst_mem_addr", mem_addr, 10'h000);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    set_port(1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // ---------------- table-driven single transactions ----------------
    vt[0] = '{1'b0, 1'b0, 10'h004, 4'hF, 32'h0,        1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 2, -1, 32'h0,        32'hDEADBEEF};
    vt[1] = '{1'b1, 1'b1, 10'h010, 4'hF, 32'h12345678, 1'b1, 32'h00000000, 32'h0,        2,  1, 32'h12345678, 32'h12345678};
    vt[2] = '{1'b0, 1'b0, 10'h010, 4'hF, 32'h0,        1'b0, 32'h0,        32'h12345678, 2, -1, 32'h0,        32'h12345678};
    vt[3] = '{1'b0, 1'b1, 10'h020, 4'h5, 32'h11223344, 1'b1, 32'hAABBCCDD, 32'h0,        3,  2, 32'hAA22CC44, 32'hAA22CC44};
    vt[4] = '{1'b1, 1'b1, 10'h030, 4'h0, 32'hFFFFFFFF, 1'b1, 32'h55555555, 32'h0,        2, -1, 32'h0,        32'h55555555};
    vt[5] = '{1'b1, 1'b0, 10'h3FF, 4'hF, 32'h0,        1'b1, 32'hCAFEF00D, 32'hCAFEF00D, 2, -1, 32'h0,        32'hCAFEF00D};
    vt[6] = '{1'b1, 1'b1, 10'h3FF, 4'h8, 32'h99887766, 1'b1, 32'h01020304, 32'h0,        3,  2, 32'h99020304, 32'h99020304};
    vt[7] = '{1'b0, 1'b1, 10'h000, 4'h3, 32'hAAAABBBB, 1'b1, 32'h11112222, 32'h0,        3,  2, 32'h1111BBBB, 32'h1111BBBB};
    for (int k = 0; k < 8; k++) begin
      if (vt[k].pre) preload(vt[k].addr, vt[k].init);
      do_req(vt[k].port, vt[k].wen, vt[k].addr, vt[k].be, vt[k].wdata, lat, rd, nwen, woff, wwd, od);
      chk($sformatf("v%0d_latency", k), lat, vt[k].exp_lat);
      chk($sformatf("v%0d_rdata", k), rd, vt[k].exp_rdata);
      chk($sformatf("v%0d_other_done", k), od, 1'b0);
      chk($sformatf("v%0d_wen_count", k), nwen, (vt[k].exp_wen_off < 0) ? 0 : 1);
      chk($sformatf("v%0d_wen_offset", k), woff, vt[k].exp_wen_off);
      if (vt[k].exp_wen_off >= 0) chk($sformatf("v%0d_wdata", k), wwd, vt[k].exp_wdata);
      chk($sformatf("v%0d_word", k), mem[vt[k].addr], vt[k].exp_word);
    end

    // ---------------- contention from reset ----------------
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    set_port(1'b0, 1'b1, 1'b0, 10'h001, 4'hF, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 10'h002, 4'hF, 32'h0);
    ng = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      @(negedge clk);
      if (m0_ready || m1_ready) begin
        g[ng] = (m0_ready && m1_ready) ? 2 : (m1_ready ? 1 : 0);
        t[ng] = cyc; ng++;
      end
    end
    set_port(1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    set_port(1'b1, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    chk("arb_grant_count", ng, 4);
    for (int k = 0; k < ng; k++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      chk($sformatf("arb_grant%0d", k), g[k], 0);
`else
      chk($sformatf("arb_grant%0d", k), g[k], k % 2);
`endif
      if (k > 0) chk($sformatf("arb_spacing%0d", k), t[k] - t[k-1], 3);
    end
    repeat (5) @(posedge clk);

    // ---------------- reset during MERGE_WR ----------------
    preload(10'h040, 32'h12345678);
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b1, 10'h040, 4'h1, 32'h000000EE);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = m0_ready;
      @(posedge clk); #1;
    end
    chk("abort_accepted", seen, 1'b1);
    set_port(1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);   // now in ACCESS
    @(posedge clk); #1 rst = 1'b1;                 // now in MERGE_WR
    @(negedge clk);
    chk("abort_mem_wen", mem_wen, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    od = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (m0_done || m1_done || mem_wen) od = 1'b1;
    end
    chk("abort_no_done_or_write", od, 1'b0);
    chk("abort_word", mem[10'h040], 32'h12345678);
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b0, 10'h040, 4'hF, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 10'h041, 4'hF, 32'h0);
    @(negedge clk);
    chk("abort_then_grant", {m0_ready, m1_ready}, 2'b10);
    @(posedge clk); #1;
    set_port(1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    set_port(1'b1, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    repeat (4) @(posedge clk);

    // ---------------- randomized traffic ----------------
    rst_pulse();
    for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
    m_rr = 1'b0; m_infl = 1'b0; rnd_on = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #1;
      if (m0_req && !rdy0_seen) begin
        if ($urandom_range(7) == 0) m0_req = 1'b0;
      end else begin
        t0 = $urandom_range(3);
        set_port(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 10'($urandom_range(15)),
                 (t0 == 0) ? 4'hF : ((t0 == 1) ? 4'h0 : 4'($urandom_range(15))), $urandom);
      end
      if (m1_req && !rdy1_seen) begin
        if ($urandom_range(7) == 0) m1_req = 1'b0;
      end else begin
        t0 = $urandom_range(3);
        set_port(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 10'($urandom_range(15)),
                 (t0 == 0) ? 4'hF : ((t0 == 1) ? 4'h0 : 4'($urandom_range(15))), $urandom);
      end
    end
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (6) @(posedge clk);
    #1 rnd_on = 1'b0;
    for (int i = 0; i < 16; i++) chk($sformatf("rnd_final_word%0d", i), mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
